// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite master driven by a simple mode/size/index request.
// Optional macro AHB_MASTER_RETRY_EN reissues ERROR-terminated transfers up to twice.
module ahb_master #(
    parameter logic [31:0] BASE_ADDR0 = 32'h0000_0000,
    parameter logic [31:0] BASE_ADDR1 = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [1:0]  mode,
    input  logic [1:0]  size,
    input  logic [19:0] pixNum,
    input  logic [31:0] wdata,
    input  logic        startAddr_sel,
    output logic [31:0] rdata,
    output logic        data_feedback,
    output logic        ahb_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DONE} state_t;

    state_t      state, state_nxt;
    logic        req;
    logic        start;
    logic        ok_end;
    logic        err_end;
    logic        retry_avail;
    logic        retry_go;
    logic        err_flag;
    logic [1:0]  eff_size;
    logic [31:0] addr_calc;

    always_comb begin
        req       = (mode == 2'b01) || (mode == 2'b10);
        eff_size  = (size == 2'b11) ? 2'b10 : size;
        addr_calc = (startAddr_sel ? BASE_ADDR1 : BASE_ADDR0) + ({12'b0, pixNum} << eff_size);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // DONE also samples the request so a held mode reissues NONSEQ right after the pulse.
    always_comb begin
        state_nxt     = state;
        HTRANS        = 2'b00;
        data_feedback = 1'b0;
        ahb_err       = 1'b0;
        start         = 1'b0;
        ok_end        = 1'b0;
        err_end       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    start     = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                HTRANS = 2'b10;
                if (HREADY) state_nxt = DATA;
            end
            DATA: begin
                if (HREADY) begin
                    if (HRESP) err_end = 1'b1;
                    else       ok_end  = 1'b1;
                    state_nxt = DONE;
                end else if (HRESP) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                if (HREADY) begin
                    err_end   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                data_feedback = 1'b1;
                ahb_err       = err_flag;
                if (req) begin
                    start     = 1'b1;
                    state_nxt = ADDR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (err_end && retry_avail) state_nxt = ADDR;
    end

`ifdef AHB_MASTER_RETRY_EN
    logic [1:0] retry_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        retry_cnt <= '0;
        else if (start)    retry_cnt <= '0;
        else if (retry_go) retry_cnt <= retry_cnt + 2'd1;
    end

    assign retry_avail = (retry_cnt != 2'd2);
`else
    assign retry_avail = 1'b0;
`endif

    assign retry_go = err_end && retry_avail;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            HADDR    <= '0;
            HSIZE    <= 3'b010;
            HWRITE   <= 1'b0;
            HWDATA   <= '0;
            rdata    <= '0;
            err_flag <= 1'b0;
        end else begin
            if (start) begin
                HADDR    <= addr_calc;
                HSIZE    <= {1'b0, eff_size};
                HWRITE   <= (mode == 2'b10);
                HWDATA   <= wdata;
                err_flag <= 1'b0;
            end
            if (ok_end && !HWRITE)     rdata    <= HRDATA;
            if (err_end && !retry_go)  err_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: per-cycle schedule model plus literal pins.
module tb_ahb_master;

    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0010_0000;
    localparam logic [31:0] BW = 32'hFFFF_FF00;
`ifdef AHB_MASTER_RETRY_EN
    localparam int RETRIES = 2;
`else
    localparam int RETRIES = 0;
`endif

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic [1:0]  mode, size;
    logic [19:0] pixNum;
    logic [31:0] wdata;
    logic        startAddr_sel;
    logic [31:0] rdata;
    logic        data_feedback, ahb_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;

    logic [31:0] w_rdata, w_HADDR, w_HWDATA;
    logic        w_fb, w_err, w_HWRITE;
    logic [1:0]  w_HTRANS;
    logic [2:0]  w_HSIZE;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fb_cyc = -1;
    int start_cyc = 0;
    int addr_phases = 0;
    int err_pulses = 0;
    bit chk_en = 1'b0;

    logic [1:0]  exp_htrans;
    logic [31:0] exp_haddr, exp_hwdata, exp_rdata;
    logic [2:0]  exp_hsize;
    logic        exp_hwrite, exp_fb, exp_err;

    ahb_master dut (
        .clk(tb_clk), .n_rst(n_rst), .mode(mode), .size(size), .pixNum(pixNum),
        .wdata(wdata), .startAddr_sel(startAddr_sel), .rdata(rdata),
        .data_feedback(data_feedback), .ahb_err(ahb_err), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Second instance near the top of the address space exercises modulo-2^32 wrap.
    ahb_master #(.BASE_ADDR0(BW)) u_wrap (
        .clk(tb_clk), .n_rst(n_rst), .mode(mode), .size(size), .pixNum(pixNum),
        .wdata(wdata), .startAddr_sel(startAddr_sel), .rdata(w_rdata),
        .data_feedback(w_fb), .ahb_err(w_err), .HADDR(w_HADDR),
        .HTRANS(w_HTRANS), .HWRITE(w_HWRITE), .HSIZE(w_HSIZE), .HWDATA(w_HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge tb_clk) begin
        if (chk_en) begin
            chk32("htrans", 32'(HTRANS), 32'(exp_htrans));
            chk32("haddr", HADDR, exp_haddr);
            chk32("hsize", 32'(HSIZE), 32'(exp_hsize));
            chk32("hwrite", 32'(HWRITE), 32'(exp_hwrite));
            chk32("hwdata", HWDATA, exp_hwdata);
            chk32("rdata", rdata, exp_rdata);
            chk32("feedback", 32'(data_feedback), 32'(exp_fb));
            chk32("ahb_err", 32'(ahb_err), 32'(exp_err));
            if (data_feedback) fb_cyc = cyc;
            if (ahb_err) err_pulses++;
            if (HTRANS == 2'b10 && HREADY) addr_phases++;
        end
    end

    task automatic cycle();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic set_reset_exp();
        exp_htrans = 2'b00; exp_haddr = '0; exp_hsize = 3'b010; exp_hwrite = 1'b0;
        exp_hwdata = '0; exp_rdata = '0; exp_fb = 1'b0; exp_err = 1'b0;
    endtask

    // aw: ADDR-phase wait cycles; dw: DATA-phase wait cycles; nerr: consecutive ERROR responses.
    task automatic run_xfer(input logic [1:0] m, input logic [1:0] sz, input logic [19:0] pix,
                            input logic sel, input logic [31:0] wd, input logic [31:0] rd,
                            input int aw, input int dw, input int nerr,
                            input bit hold, input bit chained, input bit wiggle);
        logic [1:0]  es;
        logic [31:0] addr;
        bit          fin_err;
        fin_err = 1'b0;
        es   = (sz == 2'b11) ? 2'b10 : sz;
        addr = (sel ? B1 : B0) + ({12'b0, pix} << es);
        if (!chained) begin
            mode = m; size = sz; pixNum = pix; startAddr_sel = sel; wdata = wd;
            HREADY = 1'b1; HRESP = 1'b0;
            cycle();
        end
        start_cyc = cyc;
        if (!hold) mode = 2'b00;
        for (int a = 0; ; a++) begin
            exp_htrans = 2'b10; exp_haddr = addr; exp_hsize = {1'b0, es};
            exp_hwrite = (m == 2'b10); exp_hwdata = wd;
            for (int w = 0; w < aw; w++) begin
                HREADY = 1'b0; cycle();
            end
            HREADY = 1'b1; HRESP = 1'b0; cycle();
            exp_htrans = 2'b00;
            if (wiggle) begin
                mode = 2'b10; pixNum = ~pix;
            end
            if (a < nerr) begin
                HRDATA = 32'hBAD0_0BAD;
                HREADY = 1'b0; HRESP = 1'b1; cycle();
                HREADY = 1'b1; HRESP = 1'b1; cycle();
                HRESP = 1'b0;
                if (a == RETRIES) begin
                    fin_err = 1'b1;
                    break;
                end
            end else begin
                for (int w = 0; w < dw; w++) begin
                    HRDATA = 32'h5555_AAAA; HREADY = 1'b0; HRESP = 1'b0; cycle();
                end
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = rd; cycle();
                if (m == 2'b01) exp_rdata = rd;
                break;
            end
        end
        exp_fb = 1'b1; exp_err = fin_err;
        HRDATA = 32'hDEAD_BEEF;
        pixNum = pix;
        if (!hold) mode = 2'b00;
        cycle();
        exp_fb = 1'b0; exp_err = 1'b0;
    endtask

    initial begin
        int ph0, ep0;
        n_rst = 1'b0; mode = 2'b00; size = 2'b00; pixNum = '0; wdata = '0;
        startAddr_sel = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        set_reset_exp();
        cycle(); cycle();
        chk32("rst_htrans", 32'(HTRANS), 32'h0);
        chk32("rst_hsize", 32'(HSIZE), 32'h2);
        chk32("rst_haddr", HADDR, 32'h0);
        chk32("rst_fb", 32'(data_feedback), 32'h0);
        n_rst = 1'b1;
        chk_en = 1'b1;
        cycle();

        // Zero-wait word read
        run_xfer(2'b01, 2'b10, 20'd481, 1'b0, 32'h0, 32'h0000_00FF, 0, 0, 0, 0, 0, 0);
        chk32("rd_latency", 32'(fb_cyc - start_cyc + 1), 32'd3);
        chk32("rd_haddr", HADDR, 32'h0000_0784);
        chk32("rd_rdata", rdata, 32'h0000_00FF);

        // Reset asserted in the middle of a DATA wait
        mode = 2'b01; size = 2'b10; pixNum = 20'd10; startAddr_sel = 1'b0; wdata = 32'h1111_2222;
        cycle();
        mode = 2'b00;
        exp_htrans = 2'b10; exp_haddr = 32'd40; exp_hsize = 3'b010; exp_hwrite = 1'b0;
        exp_hwdata = 32'h1111_2222;
        HREADY = 1'b1; cycle();
        exp_htrans = 2'b00;
        HREADY = 1'b0;
        #2;
        n_rst = 1'b0;
        set_reset_exp();
        #1;
        chk32("mid_rst_htrans", 32'(HTRANS), 32'h0);
        chk32("mid_rst_rdata", rdata, 32'h0);
        chk32("mid_rst_hwdata", HWDATA, 32'h0);
        chk32("mid_rst_hsize", 32'(HSIZE), 32'h2);
        cycle(); cycle();
        n_rst = 1'b1; HREADY = 1'b1;
        fb_cyc = -1;
        cycle(); cycle(); cycle();
        chk32("no_fb_after_rst", 32'(fb_cyc), 32'hFFFF_FFFF);

        // Write with one ADDR and one DATA wait state
        run_xfer(2'b10, 2'b10, 20'd1, 1'b1, 32'hA5A5_0001, 32'h0, 1, 1, 0, 0, 0, 0);
        chk32("wr_latency", 32'(fb_cyc - start_cyc + 1), 32'd5);
        chk32("wr_haddr", HADDR, 32'h0010_0004);
        chk32("wr_hwrite", 32'(HWRITE), 32'h1);
        chk32("wr_hwdata", HWDATA, 32'hA5A5_0001);

        // Byte, halfword and reserved-size transfers
        run_xfer(2'b01, 2'b00, 20'd3, 1'b1, 32'h0, 32'h0000_0042, 0, 0, 0, 0, 0, 0);
        chk32("byte_haddr", HADDR, 32'h0010_0003);
        run_xfer(2'b01, 2'b01, 20'd7, 1'b0, 32'h0, 32'hCAFE_0007, 0, 2, 0, 0, 0, 0);
        chk32("half_haddr", HADDR, 32'h0000_000E);
        run_xfer(2'b10, 2'b11, 20'd2, 1'b0, 32'h0BAD_F00D, 32'h0, 0, 0, 0, 0, 0, 0);
        chk32("rsvd_hsize", 32'(HSIZE), 32'h2);

        // ERROR response on a read
        ph0 = addr_phases; ep0 = err_pulses;
        run_xfer(2'b01, 2'b10, 20'd5, 1'b0, 32'h0, 32'h0, 0, 0, 3, 0, 0, 0);
        chk32("err_rdata_kept", rdata, 32'hCAFE_0007);
        chk32("err_pulses", 32'(err_pulses - ep0), 32'd1);
        chk32("err_addr_phases", 32'(addr_phases - ph0), 32'(RETRIES + 1));

        // Inputs changed during DATA, then reserved mode in IDLE
        run_xfer(2'b01, 2'b10, 20'h00ABC, 1'b1, 32'h0, 32'h1357_9BDF, 0, 1, 0, 0, 0, 1);
        chk32("wiggle_haddr", HADDR, 32'h0010_2AF0);
        ph0 = addr_phases;
        mode = 2'b11;
        for (int i = 0; i < 4; i++) cycle();
        mode = 2'b00;
        cycle();
        chk32("mode11_no_xfer", 32'(addr_phases - ph0), 32'd0);

        // Address wrap past 2^32 on the high-base instance
        run_xfer(2'b01, 2'b10, 20'hFFFFF, 1'b0, 32'h0, 32'h2468_ACE0, 0, 0, 0, 0, 0, 0);
        chk32("wrap_haddr", w_HADDR, 32'h003F_FEFC);
        chk32("wrap_model", w_HADDR, BW + ({12'b0, 20'hFFFFF} << 2));

        // Back-to-back reads with mode held
        run_xfer(2'b01, 2'b10, 20'd9, 1'b0, 32'h0, 32'h0000_1111, 0, 0, 0, 1, 0, 0);
        chk32("b2b_nonseq", 32'(HTRANS), 32'h2);
        run_xfer(2'b01, 2'b10, 20'd9, 1'b0, 32'h0, 32'h0000_2222, 0, 0, 0, 0, 1, 0);
        chk32("b2b_latency", 32'(fb_cyc - start_cyc + 1), 32'd3);
        chk32("b2b_rdata", rdata, 32'h0000_2222);
        cycle(); cycle();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
